spi_master_transmitter: RTL

SPI master (initiator) for the slave side of the team's SPI link. It drives SS, SCK and MOSI, and shifts in MISO.
- One transaction exchanges a DATA_WIDTH-bit word in each direction, MSB first.
- Supports all four {CKP,CPH} modes.
- SCK is generated from the system clock by a programmable divider.

---
 rtl/spi_master_transmitter.sv | 148 ++++++++++++++
 1 files changed

// File: rtl/spi_master_transmitter.sv
// SPI master: shifts one DATA_WIDTH-bit word out on MOSI and in on MISO, MSB first,
// in any {CKP,CPH} mode, with SCK divided down from CLK by CLK_DIV.
module spi_master_transmitter #(
  parameter int DATA_WIDTH = 16,
  parameter int CLK_DIV    = 4
) (
  input  logic                  CLK,
  input  logic                  RESET,
  input  logic                  start_transaction,
  input  logic                  CKP,
  input  logic                  CPH,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  MISO,
  output logic                  SCK,
  output logic                  SS,
  output logic                  MOSI,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  busy,
  output logic                  done,
  output logic [1:0]            fsm_state
);

  localparam int DIV_W  = $clog2(CLK_DIV) + 1;
  localparam int EDGE_W = $clog2(2 * DATA_WIDTH) + 1;
  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(CLK_DIV - 1);
  localparam logic [EDGE_W-1:0] EDGE_LAST = EDGE_W'(2 * DATA_WIDTH);
  localparam logic [EDGE_W-1:0] EDGE_ONE  = EDGE_W'(1);

  typedef enum logic [1:0] {IDLE, SETUP, TRANSFER, HOLD} state_t;

  state_t                state;
  logic                  prev_start;
  logic [DIV_W-1:0]      div_cnt;
  logic [EDGE_W-1:0]     edge_cnt;
  logic [DATA_WIDTH-1:0] tx_shift;
  logic [DATA_WIDTH-1:0] rx_shift;
  logic                  mode_ckp;
  logic                  mode_cph;

  logic                  start_pulse;
  logic [EDGE_W-1:0]     edge_next;
  logic                  leading;

  assign start_pulse = start_transaction & ~prev_start;
  assign edge_next   = edge_cnt + EDGE_ONE;
  // Toggle numbers start at 1; odd toggles move SCK away from its idle level.
  assign leading     = edge_next[0];
  assign fsm_state   = state;

  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state      <= IDLE;
      prev_start <= 1'b0;
      div_cnt    <= '0;
      edge_cnt   <= '0;
      tx_shift   <= '0;
      rx_shift   <= '0;
      mode_ckp   <= 1'b0;
      mode_cph   <= 1'b0;
      SS         <= 1'b1;
      SCK        <= 1'b0;
      MOSI       <= 1'b0;
      rx_data    <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      prev_start <= start_transaction;
      done       <= 1'b0;
      case (state)
        IDLE: begin
          SS       <= 1'b1;
          busy     <= 1'b0;
          MOSI     <= 1'b0;
          SCK      <= CKP;
          div_cnt  <= '0;
          edge_cnt <= '0;
          if (start_pulse) begin
            tx_shift <= tx_data;
            rx_shift <= '0;
            mode_ckp <= CKP;
            mode_cph <= CPH;
            SS       <= 1'b0;
            busy     <= 1'b1;
            state    <= SETUP;
            if (!CPH) MOSI <= tx_data[DATA_WIDTH-1];
          end
        end

        SETUP: begin
          SCK <= mode_ckp;
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            edge_cnt <= '0;
            state    <= TRANSFER;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        TRANSFER: begin
          if (div_cnt == DIV_LAST) begin
            div_cnt  <= '0;
            SCK      <= ~SCK;
            edge_cnt <= edge_next;
            if (leading) begin
              if (!mode_cph) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
              end else if (edge_next == EDGE_ONE) begin
                MOSI <= tx_shift[DATA_WIDTH-1];
              end else begin
                tx_shift <= tx_shift << 1;
                MOSI     <= tx_shift[DATA_WIDTH-2];
              end
            end else begin
              if (mode_cph) begin
                rx_shift <= {rx_shift[DATA_WIDTH-2:0], MISO};
              end else if (edge_next != EDGE_LAST) begin
                tx_shift <= tx_shift << 1;
                MOSI     <= tx_shift[DATA_WIDTH-2];
              end
            end
            if (edge_next == EDGE_LAST) state <= HOLD;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        HOLD: begin
          SCK <= mode_ckp;
          if (div_cnt == DIV_LAST) begin
            div_cnt <= '0;
            SS      <= 1'b1;
            busy    <= 1'b0;
            rx_data <= rx_shift;
            done    <= 1'b1;
            MOSI    <= 1'b0;
            state   <= IDLE;
          end else begin
            div_cnt <= div_cnt + DIV_W'(1);
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule
